// File: rtl/alu_sequencer.sv
// Four-state control unit for the external 4-bit ALU: latch, decode/operand fetch,
// execute, write back. Register file is local; bad ops retire with errFlag.
module alu_sequencer #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int INSTR_W  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instrValid,
  output logic               instrReady,
  input  logic [INSTR_W-1:0] instr,
  output logic [DATA_W-1:0]  aluA,
  output logic [DATA_W-1:0]  aluB,
  output logic [3:0]         aluOpcode,
  input  logic [DATA_W-1:0]  aluResult,
  input  logic               aluZero,
  output logic               done,
  output logic               errFlag,
  output logic               zeroFlag,
  output logic [DATA_W-1:0]  resultOut,
  input  logic [1:0]         dbgAddr,
  output logic [DATA_W-1:0]  dbgData
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [3:0] OP_DIV = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_NOP = 4'b1111;

  // instruction class resolved in DECODE and carried to WB
  localparam logic [1:0] K_ALU = 2'd0;
  localparam logic [1:0] K_LDI = 2'd1;
  localparam logic [1:0] K_NOP = 2'd2;
  localparam logic [1:0] K_ERR = 2'd3;

  typedef struct packed {
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic [1:0] lo;
  } instr_t;

  logic [1:0]                         state;
  instr_t                             ir;
  logic [1:0]                         kind;
  logic [DATA_W-1:0]                  res_q;
  logic                               zero_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]    rf;

  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic [DATA_W-1:0] imm;
  logic              is_alu;
  logic [1:0]        dec_kind;

  assign rs1_val    = rf[ir.rs1];
  assign rs2_val    = rf[ir.rs2];
  assign imm        = DATA_W'({ir.rs2, ir.lo});
  assign instrReady = (state == S_IDLE);
  assign dbgData    = rf[dbgAddr];

  // Only 0000-0110 ever reach the ALU; divide-by-zero is trapped here too.
  always_comb begin
    is_alu   = (ir.op <= OP_NOR);
    dec_kind = K_ERR;
    if (is_alu) begin
      if ((ir.op == OP_DIV) && (rs2_val == '0)) dec_kind = K_ERR;
      else                                      dec_kind = K_ALU;
    end else if (ir.op == OP_LDI) begin
      dec_kind = K_LDI;
    end else if (ir.op == OP_NOP) begin
      dec_kind = K_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      kind      <= K_NOP;
      aluA      <= '0;
      aluB      <= '0;
      aluOpcode <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      done      <= 1'b0;
      errFlag   <= 1'b0;
      zeroFlag  <= 1'b0;
      resultOut <= '0;
      rf        <= '0;
    end else begin
      done    <= 1'b0;
      errFlag <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instrValid) begin
            ir    <= instr_t'(instr[11:0]);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          kind <= dec_kind;
          if (dec_kind == K_ALU) begin
            aluA      <= rs1_val;
            aluB      <= rs2_val;
            aluOpcode <= ir.op;
          end
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (kind == K_ALU) begin
            res_q  <= aluResult;
            zero_q <= aluZero;
          end
          // done/errFlag are high for exactly the WB cycle
          done    <= 1'b1;
          errFlag <= (kind == K_ERR);
          state   <= S_WB;
        end
        default: begin
          case (kind)
            K_ALU: begin
              rf[ir.rd] <= res_q;
              resultOut <= res_q;
              zeroFlag  <= zero_q;
            end
            K_LDI: begin
              rf[ir.rd] <= imm;
              resultOut <= imm;
            end
            default: ;
          endcase
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: stimulus pushes hand-computed expectations,
// a monitor pops them on each done pulse. A small ALU model closes the loop.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instrValid = 1'b0;
  logic        instrReady;
  logic [11:0] instr = '0;
  logic [3:0]  aluA, aluB, aluOpcode, aluResult;
  logic        aluZero;
  logic        done, errFlag, zeroFlag;
  logic [3:0]  resultOut;
  logic [1:0]  dbgAddr = '0;
  logic [3:0]  dbgData;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
    .instr(instr), .aluA(aluA), .aluB(aluB), .aluOpcode(aluOpcode),
    .aluResult(aluResult), .aluZero(aluZero), .done(done), .errFlag(errFlag),
    .zeroFlag(zeroFlag), .resultOut(resultOut), .dbgAddr(dbgAddr), .dbgData(dbgData)
  );

  always #5 clk = ~clk;

  // ALU environment
  logic [7:0] prod;
  always_comb begin
    prod = aluA * aluB;
    case (aluOpcode)
      4'd0: aluResult = aluA & aluB;
      4'd1: aluResult = aluA | aluB;
      4'd2: aluResult = aluA + aluB;
      4'd3: aluResult = prod[3:0];
      4'd4: aluResult = (aluB != 0) ? aluA / aluB : 4'd0;
      4'd5: aluResult = aluA - aluB;
      4'd6: aluResult = ~(aluA | aluB);
      default: aluResult = 4'd0;
    endcase
    aluZero = (aluResult == 4'd0);
  end

  typedef struct {
    logic       err;
    logic [3:0] opc;
    logic [3:0] res;
    logic       zf;
    logic [1:0] rd;
    logic [3:0] rdval;
  } exp_t;

  exp_t sb[$];
  int   acc_q[$];
  int   n_vec = 0, n_bad = 0;
  int   cyc = 0;
  int   acc_cnt = 0, acc_last = 0, acc_gap = 0;
  bit   mon_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [3:0] opc, input logic [3:0] res,
                              input logic zf, input logic [1:0] rd, input logic [3:0] rdval);
    exp_t e;
    e.err = err; e.opc = opc; e.res = res; e.zf = zf; e.rd = rd; e.rdval = rdval;
    return e;
  endfunction

  function automatic logic [11:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 2'b00};
  endfunction

  function automatic logic [11:0] ldi(input logic [1:0] rd, input logic [3:0] imm);
    return {4'b1000, rd, 2'b00, imm};
  endfunction

  // accept tracker: handshake happens at the posedge following this sample
  always @(negedge clk) begin
    if (reset) begin
      acc_q.delete();
    end else if (instrValid && instrReady) begin
      acc_q.push_back(cyc);
      acc_gap  = cyc - acc_last;
      acc_last = cyc;
      acc_cnt++;
    end
  end

  // monitor
  initial begin
    exp_t e;
    int   lat;
    wait (reset == 1'b0);
    @(negedge clk);
    chk("rst_ready", instrReady, 1);
    chk("rst_aluA", aluA, 0);
    chk("rst_aluB", aluB, 0);
    chk("rst_opc", aluOpcode, 0);
    chk("rst_done", done, 0);
    chk("rst_err", errFlag, 0);
    chk("rst_zf", zeroFlag, 0);
    chk("rst_res", resultOut, 0);
    for (int a = 0; a < 4; a++) begin
      dbgAddr = 2'(a);
      @(negedge clk);
      chk("rst_dbg", dbgData, 0);
    end
    mon_ready = 1;
    forever begin
      @(negedge clk);
      if (!reset && done) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no retire (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("errFlag", errFlag, e.err);
          chk("aluOpcode", aluOpcode, e.opc);
          lat = (acc_q.size() != 0) ? cyc - acc_q.pop_front() : -1;
          chk("latency", lat, 3);
          dbgAddr = e.rd;
          @(negedge clk);
          chk("done_pulse", done, 0);
          chk("resultOut", resultOut, e.res);
          chk("zeroFlag", zeroFlag, e.zf);
          chk("reg_rd", dbgData, e.rdval);
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instrReady && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instrReady) chk("ready_timeout", instrReady, 1);
  endtask

  task automatic send(input logic [11:0] i, input exp_t e);
    wait_ready();
    sb.push_back(e);
    instr      = i;
    instrValid = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !instrReady) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 8'(sb.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // stimulus
  initial begin
    int c0, n;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n = 0;
    while (!mon_ready && n < 50) begin @(posedge clk); #1; n++; end

    send(ldi(1, 5),         mk(0, 0, 5, 0, 1, 5));
    send(ldi(2, 3),         mk(0, 0, 3, 0, 2, 3));
    send(enc(2, 3, 1, 2),   mk(0, 2, 8, 0, 3, 8));    // ADD 5+3
    send(enc(5, 0, 2, 2),   mk(0, 5, 0, 1, 0, 0));    // SUB 3-3
    send(ldi(1, 9),         mk(0, 5, 9, 1, 1, 9));
    send(ldi(2, 9),         mk(0, 5, 9, 1, 2, 9));
    send(enc(2, 3, 1, 2),   mk(0, 2, 2, 0, 3, 2));    // ADD 9+9 wraps
    send(ldi(1, 5),         mk(0, 2, 5, 0, 1, 5));
    send(ldi(2, 3),         mk(0, 2, 3, 0, 2, 3));
    send(enc(3, 3, 1, 2),   mk(0, 3, 15, 0, 3, 15));  // MUL 5*3
    send(ldi(2, 0),         mk(0, 3, 0, 0, 2, 0));
    send(enc(5, 0, 2, 2),   mk(0, 5, 0, 1, 0, 0));
    send(ldi(1, 7),         mk(0, 5, 7, 1, 1, 7));
    send(enc(4, 3, 1, 2),   mk(1, 5, 7, 1, 3, 15));   // DIV by zero
    send(ldi(2, 2),         mk(0, 5, 2, 1, 2, 2));
    send(enc(4, 3, 1, 2),   mk(0, 4, 3, 0, 3, 3));    // DIV 7/2
    send(enc(7, 0, 1, 2),   mk(1, 4, 3, 0, 0, 0));    // illegal 0111
    send(enc(10, 1, 1, 2),  mk(1, 4, 3, 0, 1, 7));    // illegal 1010
    send(enc(15, 2, 1, 2),  mk(0, 4, 3, 0, 2, 2));    // NOP
    send(enc(2, 1, 1, 1),   mk(0, 2, 14, 0, 1, 14));  // rd == rs1 == rs2
    drain();

    // valid held 8 cycles; instr changes while busy and must be ignored
    c0 = acc_cnt;
    wait_ready();
    sb.push_back(mk(0, 2, 6, 0, 0, 6));                // LDI r0=6
    instr      = ldi(0, 6);
    instrValid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        sb.push_back(mk(0, 0, 6, 0, 3, 6));            // AND 14&6
        instr = enc(0, 3, 1, 0);
      end
    end
    instrValid = 1'b0;
    drain();
    chk("hold_accepts", 8'(acc_cnt - c0), 2);
    chk("hold_gap", 8'(acc_gap), 4);

    send(enc(6, 2, 1, 0),   mk(0, 6, 1, 0, 2, 1));    // NOR ~(14|6)
    drain();

    // reset while the ADD is in EXEC: no retire, no write
    wait_ready();
    instr      = enc(2, 3, 1, 2);
    instrValid = 1'b1;
    @(posedge clk); #1;
    instrValid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ready_after_reset", instrReady, 1);
    chk("res_after_reset", resultOut, 0);
    chk("opc_after_reset", aluOpcode, 0);
    repeat (6) @(posedge clk);
    #1;
    send(enc(2, 3, 1, 2),   mk(0, 2, 0, 1, 3, 0));    // all regs cleared
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
